// File: rtl/ctrl_ringbuf_seq_pkg.sv
// Shared types and defaults for the ring-buffer sample sequencer family.
package ctrl_ringbuf_seq_pkg;

  localparam int unsigned DataAddrWidthDflt = 12;
  localparam int unsigned DataOffWidthDflt  = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StWrite = 2'b01,
    StRun   = 2'b10,
    StDone  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/ctrl_ringbuf_headptr.sv
// Modulo head-offset register with length latch; shared by data/coef sequencers.
module ctrl_ringbuf_headptr #(
  parameter int unsigned OFFSET_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    i_load,
  input  logic [OFFSET_WIDTH-1:0] i_len,
  output logic [OFFSET_WIDTH-1:0] o_head,
  output logic [OFFSET_WIDTH-1:0] o_len
);

  logic [OFFSET_WIDTH-1:0] r_head;
  logic [OFFSET_WIDTH-1:0] r_len;
  logic [OFFSET_WIDTH-1:0] w_head_next;

  // Compare against the new length with >= so a stale offset wraps when the ring shrinks.
  assign w_head_next = (r_head >= i_len) ? '0 : r_head + OFFSET_WIDTH'(1);

  // Latch length and advance head on each accepted sample.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_head <= '0;
      r_len  <= '0;
    end else if (i_load) begin
      r_head <= w_head_next;
      r_len  <= i_len;
    end
  end

  assign o_head = r_head;
  assign o_len  = r_len;

endmodule

// File: rtl/ctrl_ringbuf_seq.sv
// Per-channel sample sequencer: write sample at new head, then stream taps newest-to-oldest.
module ctrl_ringbuf_seq
  import ctrl_ringbuf_seq_pkg::*;
#(
  parameter int unsigned DATA_ADDRESS_WIDTH = DataAddrWidthDflt,
  parameter int unsigned DATA_OFFSET_WIDTH  = DataOffWidthDflt
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          i_sample_vld,
  output logic                          o_sample_rdy,
  input  logic [DATA_OFFSET_WIDTH-1:0]  i_buf_len,
  input  logic [DATA_ADDRESS_WIDTH-1:0] i_data_uptr,
  input  logic                          i_rb_fin,
  output logic                          o_rb_init,
  output logic                          o_rb_cnt,
  output logic [DATA_OFFSET_WIDTH-1:0]  o_head_offset,
  output logic                          o_wr_en,
  output logic [DATA_ADDRESS_WIDTH-1:0] o_wr_addr,
  output logic                          o_tap_vld,
  output logic                          o_tap_last,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int unsigned TapWidth = DATA_OFFSET_WIDTH + 1;

  seq_state_e                   r_state;
  seq_state_e                   w_state_next;
  logic [TapWidth-1:0]          r_tap;
  logic                         r_err;
  logic                         w_accept;
  logic                         w_overrun;
  logic [DATA_OFFSET_WIDTH-1:0] w_head;
  logic [DATA_OFFSET_WIDTH-1:0] w_len;

  assign w_accept  = (r_state == StIdle) & i_sample_vld;
  // Driver failed to finish after len+1 taps: give up on this sample.
  assign w_overrun = (r_state == StRun) & ~i_rb_fin & (r_tap > {1'b0, w_len});

  ctrl_ringbuf_headptr #(
    .OFFSET_WIDTH (DATA_OFFSET_WIDTH)
  ) u_headptr (
    .clk    (clk),
    .clr    (clr),
    .i_load (w_accept),
    .i_len  (i_buf_len),
    .o_head (w_head),
    .o_len  (w_len)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Tap counter restarts in WRITE, counts every RUN cycle; overrun flag is sticky.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_tap <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == StWrite) begin
        r_tap <= '0;
      end else if (r_state == StRun) begin
        r_tap <= r_tap + TapWidth'(1);
      end
      if (w_overrun) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_next = r_state;
    o_sample_rdy = 1'b0;
    o_wr_en      = 1'b0;
    o_rb_init    = 1'b0;
    o_rb_cnt     = 1'b0;
    o_tap_vld    = 1'b0;
    o_tap_last   = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_sample_rdy = 1'b1;
        if (i_sample_vld) begin
          w_state_next = StWrite;
        end
      end
      StWrite: begin
        o_wr_en      = 1'b1;
        o_rb_init    = 1'b1;
        w_state_next = StRun;
      end
      StRun: begin
        o_tap_vld  = 1'b1;
        o_rb_cnt   = ~i_rb_fin;
        o_tap_last = i_rb_fin;
        if (i_rb_fin) begin
          w_state_next = StDone;
        end else if (w_overrun) begin
          o_tap_last   = 1'b1;
          w_state_next = StDone;
        end
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_wr_addr     = i_data_uptr + DATA_ADDRESS_WIDTH'(w_head);
  assign o_head_offset = w_head;
  assign o_err         = r_err;

endmodule

// File: tb/tb_ctrl_ringbuf_seq.sv
// Directed bench for ctrl_ringbuf_seq with a simple ring-buffer driver model.
module tb_ctrl_ringbuf_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        i_sample_vld;
  logic        o_sample_rdy;
  logic [9:0]  i_buf_len;
  logic [11:0] i_data_uptr;
  logic        i_rb_fin;
  logic        o_rb_init;
  logic        o_rb_cnt;
  logic [9:0]  o_head_offset;
  logic        o_wr_en;
  logic [11:0] o_wr_addr;
  logic        o_tap_vld;
  logic        o_tap_last;
  logic        o_done;
  logic        o_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Driver model: counts cnt commands after init, finishes after len counts.
  logic [10:0] m_cnt;
  logic [9:0]  m_len;
  logic        m_no_fin;

  always #5 clk = ~clk;

  ctrl_ringbuf_seq #(
    .DATA_ADDRESS_WIDTH (12),
    .DATA_OFFSET_WIDTH  (10)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .i_sample_vld  (i_sample_vld),
    .o_sample_rdy  (o_sample_rdy),
    .i_buf_len     (i_buf_len),
    .i_data_uptr   (i_data_uptr),
    .i_rb_fin      (i_rb_fin),
    .o_rb_init     (o_rb_init),
    .o_rb_cnt      (o_rb_cnt),
    .o_head_offset (o_head_offset),
    .o_wr_en       (o_wr_en),
    .o_wr_addr     (o_wr_addr),
    .o_tap_vld     (o_tap_vld),
    .o_tap_last    (o_tap_last),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      m_cnt <= '0;
      m_len <= '0;
    end else if (o_rb_init) begin
      m_cnt <= '0;
      m_len <= i_buf_len;
    end else if (o_rb_cnt) begin
      m_cnt <= m_cnt + 11'd1;
    end
  end

  assign i_rb_fin = ~m_no_fin & (m_cnt == {1'b0, m_len});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full accept-to-idle transaction with per-cycle expectations.
  task automatic do_sample(input string tag, input logic [9:0] len, input logic [11:0] exp_addr,
                           input logic [9:0] exp_head, input int exp_taps, input logic exp_err);
    i_buf_len    = len;
    i_sample_vld = 1'b1;
    check({tag, " rdy_t0"}, 32'(o_sample_rdy), 32'd1);
    tick();
    i_sample_vld = 1'b0;
    check({tag, " wr_en"}, 32'(o_wr_en), 32'd1);
    check({tag, " rb_init"}, 32'(o_rb_init), 32'd1);
    check({tag, " wr_addr"}, 32'(o_wr_addr), 32'(exp_addr));
    check({tag, " head"}, 32'(o_head_offset), 32'(exp_head));
    check({tag, " tap_vld_t1"}, 32'(o_tap_vld), 32'd0);
    for (int t = 1; t <= exp_taps; t++) begin
      tick();
      check({tag, " tap_vld"}, 32'(o_tap_vld), 32'd1);
      check({tag, " tap_last"}, 32'(o_tap_last), 32'(t == exp_taps));
      check({tag, " init_cnt_excl"}, 32'(o_rb_init & o_rb_cnt), 32'd0);
      check({tag, " done_early"}, 32'(o_done), 32'd0);
    end
    tick();
    check({tag, " done"}, 32'(o_done), 32'd1);
    check({tag, " tap_vld_done"}, 32'(o_tap_vld), 32'd0);
    check({tag, " err"}, 32'(o_err), 32'(exp_err));
    tick();
    check({tag, " rdy_end"}, 32'(o_sample_rdy), 32'd1);
    check({tag, " done_end"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    clr          = 1'b1;
    i_sample_vld = 1'b0;
    i_buf_len    = '0;
    i_data_uptr  = 12'h100;
    m_no_fin     = 1'b0;
    tick();
    tick();
    check("rst rdy", 32'(o_sample_rdy), 32'd1);
    check("rst head", 32'(o_head_offset), 32'd0);
    check("rst err", 32'(o_err), 32'd0);
    check("rst done", 32'(o_done), 32'd0);
    check("rst tap_vld", 32'(o_tap_vld), 32'd0);
    check("rst wr_en", 32'(o_wr_en), 32'd0);
    check("rst rb_init", 32'(o_rb_init), 32'd0);
    check("rst wr_addr", 32'(o_wr_addr), 32'h100);
    clr = 1'b0;

    // Nominal then wrap: heads 1,2,3,0.
    do_sample("nom", 10'd3, 12'h101, 10'd1, 4, 1'b0);
    do_sample("wrap2", 10'd3, 12'h102, 10'd2, 4, 1'b0);
    do_sample("wrap3", 10'd3, 12'h103, 10'd3, 4, 1'b0);
    do_sample("wrap4", 10'd3, 12'h100, 10'd0, 4, 1'b0);

    // Degenerate single-tap ring.
    do_sample("degen", 10'd0, 12'h100, 10'd0, 1, 1'b0);

    // Walk head to 7 near the top of address space, then shrink the ring.
    i_data_uptr = 12'hFFE;
    for (int i = 1; i <= 7; i++) begin
      do_sample("grow", 10'd9, 12'(12'hFFE + i), 10'(i), 10, 1'b0);
    end
    do_sample("shrink", 10'd4, 12'hFFE, 10'd0, 5, 1'b0);

    // Overrun: driver never finishes.
    i_data_uptr = 12'h200;
    m_no_fin    = 1'b1;
    do_sample("ovr", 10'd2, 12'h201, 10'd1, 4, 1'b1);
    m_no_fin    = 1'b0;
    do_sample("post_ovr", 10'd2, 12'h202, 10'd2, 3, 1'b1);
    tick();
    check("err sticky", 32'(o_err), 32'd1);

    // Clear mid-RUN.
    i_data_uptr  = 12'h100;
    i_buf_len    = 10'd3;
    i_sample_vld = 1'b1;
    tick();
    i_sample_vld = 1'b0;
    tick();
    tick();
    check("mid tap_vld", 32'(o_tap_vld), 32'd1);
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    check("clr rdy", 32'(o_sample_rdy), 32'd1);
    check("clr head", 32'(o_head_offset), 32'd0);
    check("clr err", 32'(o_err), 32'd0);
    check("clr done", 32'(o_done), 32'd0);
    check("clr tap_vld", 32'(o_tap_vld), 32'd0);
    tick();
    check("clr done_after", 32'(o_done), 32'd0);
    check("clr rdy_after", 32'(o_sample_rdy), 32'd1);
    do_sample("post_clr", 10'd3, 12'h101, 10'd1, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
